softcpu_exec_core: RTL and testbench
====================================

Name: softcpu_exec_core

Overview:
- Parametrised successor to the 8-bit soft-CPU control matrix.
- Accepts one packed instruction per valid/ready handshake and executes it against an internal register file of REG_COUNT x DATA_WIDTH.
- Supports ALU ops, a multi-cycle load/store memory handshake, flags, conditional jumps and halt.
- Sits between the instruction feeder/testbench and the data memory. Maintains the instruction pointer.

Parameters:
- DATA_WIDTH, 8, operand/register width (>=4).
- REG_COUNT, 16, number of registers (power of 2, >=2).
- REG_ADDR_W, localparam clog2(REG_COUNT), destination/register index width.
- ADDR_WIDTH, localparam 2*DATA_WIDTH, memory address and instruction pointer width.
- INSTR_WIDTH, localparam 6+2*DATA_WIDTH+REG_ADDR_W; equals 26 at defaults.

Ports:
- clock  in  1  single clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  instruction presented.
- instr  in  INSTR_WIDTH  fields, MSB first:
  - opcode[4]
  - mode[2]: upper bit = A is register, lower bit = B is register
  - opA[DATA_WIDTH]
  - opB[DATA_WIDTH]
  - dest[REG_ADDR_W]
- instr_ready  out  1  high only in IDLE; transfer occurs when valid&&ready.
- instruction_pointer  out  ADDR_WIDTH  address of next instruction.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1=store, 0=load; stable while mem_req.
- mem_addr  out  ADDR_WIDTH  {opA,opB}; stable while mem_req.
- mem_wdata  out  DATA_WIDTH  reg[dest] value for store.
- mem_rdata  in  DATA_WIDTH  load data, sampled with mem_ack.
- mem_ack  in  1  completes a request; ignored when mem_req=0.
- flag_zero  out  1  last ALU result == 0.
- flag_carry  out  1  carry/borrow/shifted-out bit.
- halted  out  1  HALT executed.
- dbg_sel  in  REG_ADDR_W  debug register select.
- dbg_data  out  DATA_WIDTH  reg[dbg_sel], combinational read.

Behaviour:
- Reset (async assert, sync release):
  - all registers, instruction_pointer, flags, halted, mem_req, mem_we, mem_addr and mem_wdata are 0; state = IDLE.
  - instr_ready is 0 while reset_n=0 and 1 on the first clock after release.
  - Reset during MEM_WAIT drops mem_req immediately (combinationally via the flop reset).
- Operand resolve: if the mode bit is set, the operand value is reg[low REG_ADDR_W bits of the field]; otherwise the field is an immediate.
- FSM: IDLE, EXEC, MEM_WAIT, HALT.
  - IDLE: on the handshake, capture instr and go to EXEC; instr_ready drops the next cycle.
  - EXEC (ALU, MOV, CMP, NOP, jumps):
    - write dest, update flags and instruction_pointer at the end of EXEC, then return to IDLE.
    - ALU latency: accept at edge N, result visible at edge N+1, instr_ready high again after edge N+1.
  - EXEC (LOAD/STORE): drive mem_req=1 with mem_we/addr/wdata and go to MEM_WAIT.
  - MEM_WAIT: hold all memory outputs.
    - On mem_ack: LOAD writes mem_rdata to reg[dest]; STORE writes nothing.
    - Deassert mem_req, IP+1, go to IDLE.
    - mem_ack in the same cycle that mem_req rises is accepted.
  - HALT: halted=1, instr_ready=0; exits only on reset.
- Opcodes:
  - 0 NOP
  - 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR
  - 6 SHL (A by 1), 7 SHR (A by 1)
  - 8 MOV (dest<=A)
  - 9 LOAD, 10 STORE
  - 11 JMP, 12 JZ, 13 JC
  - 14 CMP (A-B, flags only)
  - 15 HALT
- Arithmetic and flags:
  - Results are truncated to DATA_WIDTH.
  - ADD: carry = bit DATA_WIDTH of the sum.
  - SUB/CMP: carry = borrow (A<B).
  - SHL: carry = old MSB. SHR: carry = old LSB.
  - AND/OR/XOR/MOV: carry cleared, zero updated.
  - NOP, LOAD, STORE and jumps leave flags unchanged.
- Instruction pointer:
  - +1 per retired non-jump instruction; wraps from all-ones to 0.
  - JMP loads {opA,opB}. JZ/JC load {opA,opB} if the flag is set, else +1.
  - HALT does not advance the IP.
- Register file: a write to dest and a dbg read of the same register in the same cycle returns the old value.
- instr is ignored whenever instr_ready=0.

Decomposition:
- Package softcpu_pkg holds:
  - opcode localparams OP_NOP..OP_HALT
  - FSM state encodings
  - instruction field offset functions (parametrised by DATA_WIDTH and REG_ADDR_W)
- Sub-module softcpu_alu: combinational; inputs op, A, B; outputs result, carry, zero.

Test Plan:
- Immediate ADD:
  - Stimulus: instr=26'b0001_00_00100111_00011001_0001, one handshake.
  - Response: reg1=8'h40, zero=0, carry=0, instruction_pointer=1, instr_ready low exactly one cycle.
- Carry:
  - Stimulus: ADD imm 8'hF0+8'h20 to dest 2.
  - Response: reg2=8'h10, carry=1.
  - Then ADD mode=11 with A=reg1 and B=reg2 to dest 4: reg4=8'h50, carry=0.
- Zero flag and conditional jump:
  - Stimulus: SUB 8'h05-8'h05 to dest 3.
  - Response: reg3=0, zero=1.
  - Then JZ opA=8'h00, opB=8'h40: instruction_pointer=16'h0040.
  - Then JC: IP=16'h0041.
- Load with wait states:
  - Stimulus: LOAD opA=8'h12, opB=8'h34 to dest 5.
  - Response: mem_req=1, mem_we=0, mem_addr=16'h1234 held for 3 cycles. mem_ack with mem_rdata=8'hAB gives reg5=8'hAB, and mem_req drops the next cycle.
  - STORE from dest 5: mem_we=1, mem_wdata=8'hAB.
- Reset mid-wait:
  - Stimulus: assert reset_n=0 during MEM_WAIT, asynchronously between clock edges.
  - Response: mem_req=0 immediately; all registers and the IP=0.
  - After release: instr_ready=1.
- Halt:
  - Stimulus: HALT, then further valid instructions.
  - Response: halted=1, instr_ready stays 0, IP frozen, registers unchanged.

Source files
------------

// File: rtl/softcpu_pkg.sv
// Shared definitions for the soft-CPU execution core: opcodes, FSM states and
// instruction field offsets.
package softcpu_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_OR    = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_SHL   = 4'd6;
  localparam logic [3:0] OP_SHR   = 4'd7;
  localparam logic [3:0] OP_MOV   = 4'd8;
  localparam logic [3:0] OP_LOAD  = 4'd9;
  localparam logic [3:0] OP_STORE = 4'd10;
  localparam logic [3:0] OP_JMP   = 4'd11;
  localparam logic [3:0] OP_JZ    = 4'd12;
  localparam logic [3:0] OP_JC    = 4'd13;
  localparam logic [3:0] OP_CMP   = 4'd14;
  localparam logic [3:0] OP_HALT  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MEM_WAIT,
    ST_HALT
  } state_e;

  // Instruction layout, MSB first: opcode[4] mode[2] opA[dw] opB[dw] dest[raw]
  function automatic int unsigned opb_lsb(input int unsigned raw);
    return raw;
  endfunction

  function automatic int unsigned opa_lsb(input int unsigned dw, input int unsigned raw);
    return dw + raw;
  endfunction

  function automatic int unsigned mode_lsb(input int unsigned dw, input int unsigned raw);
    return 2 * dw + raw;
  endfunction

  function automatic int unsigned opcode_lsb(input int unsigned dw, input int unsigned raw);
    return 2 * dw + raw + 2;
  endfunction

endpackage

// File: rtl/softcpu_alu.sv
// Combinational ALU for the soft-CPU core: arithmetic, logic and single-bit
// shifts with carry/borrow and zero outputs.
module softcpu_alu
  import softcpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [3:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  carry,
  output logic                  zero
);

  logic [DATA_WIDTH:0] sum;
  logic [DATA_WIDTH:0] diff;

  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    // Top bit of the widened difference is the borrow (a < b)
    diff   = {1'b0, a} - {1'b0, b};
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        result = sum[DATA_WIDTH-1:0];
        carry  = sum[DATA_WIDTH];
      end
      OP_SUB, OP_CMP: begin
        result = diff[DATA_WIDTH-1:0];
        carry  = diff[DATA_WIDTH];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: begin
        result = {a[DATA_WIDTH-2:0], 1'b0};
        carry  = a[DATA_WIDTH-1];
      end
      OP_SHR: begin
        result = {1'b0, a[DATA_WIDTH-1:1]};
        carry  = a[0];
      end
      OP_MOV: result = a;
      default: ;
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/softcpu_exec_core.sv
// Soft-CPU execution core: accepts one packed instruction per handshake,
// executes it against an internal register file and drives the data memory.
module softcpu_exec_core
  import softcpu_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH  = 8,
  parameter  int unsigned REG_COUNT   = 16,
  localparam int unsigned REG_ADDR_W  = $clog2(REG_COUNT),
  localparam int unsigned ADDR_WIDTH  = 2 * DATA_WIDTH,
  localparam int unsigned INSTR_WIDTH = 6 + 2 * DATA_WIDTH + REG_ADDR_W
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   instr_valid,
  input  logic [INSTR_WIDTH-1:0] instr,
  output logic                   instr_ready,
  output logic [ADDR_WIDTH-1:0]  instruction_pointer,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]  mem_wdata,
  input  logic [DATA_WIDTH-1:0]  mem_rdata,
  input  logic                   mem_ack,
  output logic                   flag_zero,
  output logic                   flag_carry,
  output logic                   halted,
  input  logic [REG_ADDR_W-1:0]  dbg_sel,
  output logic [DATA_WIDTH-1:0]  dbg_data
);

  localparam int unsigned OPC_LSB  = opcode_lsb(DATA_WIDTH, REG_ADDR_W);
  localparam int unsigned MODE_LSB = mode_lsb(DATA_WIDTH, REG_ADDR_W);
  localparam int unsigned OPA_LSB  = opa_lsb(DATA_WIDTH, REG_ADDR_W);
  localparam int unsigned OPB_LSB  = opb_lsb(REG_ADDR_W);

  state_e                 state_q, state_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]  ip_q, ip_d;
  logic                   zero_q, zero_d;
  logic                   carry_q, carry_d;
  logic                   halted_q, halted_d;
  logic                   ready_q, ready_d;
  logic                   mem_req_q, mem_req_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_d;

  logic [DATA_WIDTH-1:0]  regs_q [REG_COUNT];
  logic                   rf_we;
  logic [REG_ADDR_W-1:0]  rf_waddr;
  logic [DATA_WIDTH-1:0]  rf_wdata;

  logic [3:0]             op;
  logic [1:0]             mode;
  logic [DATA_WIDTH-1:0]  fld_a, fld_b;
  logic [REG_ADDR_W-1:0]  dest;
  logic [DATA_WIDTH-1:0]  opnd_a, opnd_b;
  logic [DATA_WIDTH-1:0]  alu_res;
  logic                   alu_carry, alu_zero;
  logic [ADDR_WIDTH-1:0]  ip_inc, jump_tgt;

  assign op    = instr_q[OPC_LSB +: 4];
  assign mode  = instr_q[MODE_LSB +: 2];
  assign fld_a = instr_q[OPA_LSB +: DATA_WIDTH];
  assign fld_b = instr_q[OPB_LSB +: DATA_WIDTH];
  assign dest  = instr_q[REG_ADDR_W-1:0];

  assign opnd_a   = mode[1] ? regs_q[fld_a[REG_ADDR_W-1:0]] : fld_a;
  assign opnd_b   = mode[0] ? regs_q[fld_b[REG_ADDR_W-1:0]] : fld_b;
  assign ip_inc   = ip_q + ADDR_WIDTH'(1);
  assign jump_tgt = {fld_a, fld_b};

  softcpu_alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
    .op     (op),
    .a      (opnd_a),
    .b      (opnd_b),
    .result (alu_res),
    .carry  (alu_carry),
    .zero   (alu_zero)
  );

  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    ip_d        = ip_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    halted_d    = halted_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rf_we       = 1'b0;
    rf_waddr    = dest;
    rf_wdata    = alu_res;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid && ready_q) begin
          instr_d = instr;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_IDLE;
        case (op)
          OP_NOP: ip_d = ip_inc;
          OP_LOAD, OP_STORE: begin
            mem_req_d   = 1'b1;
            mem_we_d    = (op == OP_STORE);
            mem_addr_d  = jump_tgt;
            mem_wdata_d = regs_q[dest];
            state_d     = ST_MEM_WAIT;
          end
          OP_JMP: ip_d = jump_tgt;
          OP_JZ:  ip_d = zero_q  ? jump_tgt : ip_inc;
          OP_JC:  ip_d = carry_q ? jump_tgt : ip_inc;
          OP_HALT: begin
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end
          default: begin
            rf_we   = (op != OP_CMP);
            zero_d  = alu_zero;
            carry_d = alu_carry;
            ip_d    = ip_inc;
          end
        endcase
      end
      ST_MEM_WAIT: begin
        if (mem_ack) begin
          rf_we     = !mem_we_q;
          rf_wdata  = mem_rdata;
          mem_req_d = 1'b0;
          ip_d      = ip_inc;
          state_d   = ST_IDLE;
        end
      end
      default: ;
    endcase
    // Ready is registered so it stays low throughout reset and rises on the first edge after release
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      instr_q     <= '0;
      ip_q        <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      halted_q    <= 1'b0;
      ready_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      ip_q        <= ip_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      halted_q    <= halted_d;
      ready_q     <= ready_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < REG_COUNT; i++) regs_q[i] <= '0;
    end else if (rf_we) begin
      regs_q[rf_waddr] <= rf_wdata;
    end
  end

  assign instr_ready         = ready_q;
  assign instruction_pointer = ip_q;
  assign mem_req             = mem_req_q;
  assign mem_we              = mem_we_q;
  assign mem_addr            = mem_addr_q;
  assign mem_wdata           = mem_wdata_q;
  assign flag_zero           = zero_q;
  assign flag_carry          = carry_q;
  assign halted              = halted_q;
  assign dbg_data            = regs_q[dbg_sel];

endmodule

// File: tb/tb_softcpu_exec_core.sv
// Directed bench for softcpu_exec_core with an instruction-level reference model
// and a per-cycle idle-state compare process.
module tb_softcpu_exec_core;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        instr_valid;
  logic [25:0] instr;
  logic        instr_ready;
  logic [15:0] instruction_pointer;
  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        flag_zero, flag_carry, halted;
  logic [3:0]  dbg_sel;
  logic [7:0]  dbg_data;

  softcpu_exec_core #(.DATA_WIDTH(8), .REG_COUNT(16)) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .instr_valid         (instr_valid),
    .instr               (instr),
    .instr_ready         (instr_ready),
    .instruction_pointer (instruction_pointer),
    .mem_req             (mem_req),
    .mem_we              (mem_we),
    .mem_addr            (mem_addr),
    .mem_wdata           (mem_wdata),
    .mem_rdata           (mem_rdata),
    .mem_ack             (mem_ack),
    .flag_zero           (flag_zero),
    .flag_carry          (flag_carry),
    .halted              (halted),
    .dbg_sel             (dbg_sel),
    .dbg_data            (dbg_data)
  );

  always #20 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference architectural state
  logic [7:0]  m_reg [16];
  logic [15:0] m_ip;
  logic        m_z, m_c, m_halted;
  logic        cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [25:0] mk(input logic [3:0] op, input logic [1:0] md,
                                     input logic [7:0] a, input logic [7:0] b,
                                     input logic [3:0] d);
    return {op, md, a, b, d};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_reg[i] = 8'h00;
    m_ip = 16'h0000; m_z = 1'b0; m_c = 1'b0; m_halted = 1'b0;
  endtask

  // Instruction semantics in plain integer arithmetic
  task automatic model_exec(input logic [25:0] ins, input logic [7:0] rd);
    logic [3:0] op, d;
    logic [1:0] md;
    logic [7:0] fa, fb;
    int a, b, r;
    bit wr, fl;
    {op, md, fa, fb, d} = ins;
    a  = md[1] ? int'(m_reg[fa[3:0]]) : int'(fa);
    b  = md[0] ? int'(m_reg[fb[3:0]]) : int'(fb);
    r  = 0; wr = 1'b1; fl = 1'b1;
    case (op)
      4'd1:  begin r = a + b; m_c = (r > 255); r = r % 256; end
      4'd2, 4'd14: begin m_c = (a < b); r = a - b; if (r < 0) r += 256; wr = (op == 4'd2); end
      4'd3:  begin r = a & b; m_c = 1'b0; end
      4'd4:  begin r = a | b; m_c = 1'b0; end
      4'd5:  begin r = a ^ b; m_c = 1'b0; end
      4'd6:  begin m_c = (a >= 128); r = (a * 2) % 256; end
      4'd7:  begin m_c = (a % 2 == 1); r = a / 2; end
      4'd8:  begin r = a; m_c = 1'b0; end
      default: begin wr = 1'b0; fl = 1'b0; end
    endcase
    if (fl) m_z = (r == 0);
    if (wr) m_reg[d] = 8'(r);
    if (op == 4'd9) m_reg[d] = rd;
    case (op)
      4'd11:   m_ip = {fa, fb};
      4'd12:   m_ip = m_z ? {fa, fb} : m_ip + 16'd1;
      4'd13:   m_ip = m_c ? {fa, fb} : m_ip + 16'd1;
      4'd15:   m_halted = 1'b1;
      default: m_ip = m_ip + 16'd1;
    endcase
  endtask

  always @(negedge clock) begin
    if (cmp_en) begin
      chk("ip", 32'(instruction_pointer), 32'(m_ip));
      chk("flag_zero", 32'(flag_zero), 32'(m_z));
      chk("flag_carry", 32'(flag_carry), 32'(m_c));
      chk("halted", 32'(halted), 32'(m_halted));
      chk("instr_ready", 32'(instr_ready), 32'(!m_halted));
      chk("mem_req_idle", 32'(mem_req), 32'd0);
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!instr_ready && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    chk("ready_wait", 32'(instr_ready), 32'd1);
  endtask

  task automatic idle();
    cmp_en = 1'b1;
    @(posedge clock); #1;
    cmp_en = 1'b0;
  endtask

  task automatic check_regs(input string name);
    for (int i = 0; i < 16; i++) begin
      dbg_sel = 4'(i);
      #1;
      chk(name, 32'(dbg_data), 32'(m_reg[i]));
    end
  endtask

  task automatic lit(input string name, input logic [3:0] sel, input logic [7:0] exp);
    dbg_sel = sel;
    #1;
    chk(name, 32'(dbg_data), 32'(exp));
  endtask

  // Non-memory, non-halt instruction: one EXEC cycle, a HALT word is held on the
  // bus during that cycle and must be ignored
  task automatic send(input logic [25:0] ins);
    logic [7:0] old;
    cmp_en = 1'b0;
    wait_ready();
    instr = ins; instr_valid = 1'b1;
    dbg_sel = ins[3:0];
    old = m_reg[ins[3:0]];
    @(posedge clock); #1;
    instr = mk(4'd15, 2'b00, 8'hFF, 8'hFF, 4'hF);
    model_exec(ins, 8'h00);
    @(negedge clock);
    chk("ready_drop", 32'(instr_ready), 32'd0);
    chk("dbg_old_value", 32'(dbg_data), 32'(old));
    @(posedge clock); #1;
    instr_valid = 1'b0;
    chk("ready_back", 32'(instr_ready), 32'd1);
    idle();
  endtask

  task automatic mem_op(input logic [25:0] ins, input int waits, input logic [7:0] rd);
    logic [7:0] exp_wdata;
    cmp_en = 1'b0;
    wait_ready();
    instr = ins; instr_valid = 1'b1;
    exp_wdata = m_reg[ins[3:0]];
    @(posedge clock); #1;
    instr_valid = 1'b0;
    if (waits == 0) begin mem_ack = 1'b1; mem_rdata = rd; end
    @(posedge clock); #1;
    for (int i = 0; i <= waits; i++) begin
      if (i == waits) begin mem_ack = 1'b1; mem_rdata = rd; end
      @(negedge clock);
      chk("mem_req_hold", 32'(mem_req), 32'd1);
      chk("mem_we", 32'(mem_we), 32'(ins[25:22] == 4'd10));
      chk("mem_addr", 32'(mem_addr), 32'(ins[19:4]));
      chk("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
      chk("ready_in_wait", 32'(instr_ready), 32'd0);
      @(posedge clock); #1;
    end
    mem_ack = 1'b0; mem_rdata = 8'h5A;
    model_exec(ins, rd);
    chk("mem_req_drop", 32'(mem_req), 32'd0);
    chk("ready_after_mem", 32'(instr_ready), 32'd1);
    idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; instr_valid = 1'b0; instr = '0;
    mem_ack = 1'b0; mem_rdata = 8'h00; dbg_sel = 4'h0;
    model_reset();
    #3;
    chk("rst_ready", 32'(instr_ready), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_ip", 32'(instruction_pointer), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    #47 reset_n = 1'b1;
    @(posedge clock); #1;
    chk("ready_after_release", 32'(instr_ready), 32'd1);
    check_regs("rst_regs");

    // Immediate ADD 0x27 + 0x19 -> reg1
    send(26'b0001_00_00100111_00011001_0001);
    lit("add_reg1", 4'd1, 8'h40);
    chk("add_ip", 32'(instruction_pointer), 32'd1);

    // Carry out of ADD, then register-register ADD
    send(mk(4'd1, 2'b00, 8'hF0, 8'h20, 4'd2));
    lit("carry_reg2", 4'd2, 8'h10);
    chk("carry_flag", 32'(flag_carry), 32'd1);
    send(mk(4'd1, 2'b11, 8'h01, 8'h02, 4'd4));
    lit("regreg_reg4", 4'd4, 8'h50);

    // Zero flag and conditional jumps
    send(mk(4'd2, 2'b00, 8'h05, 8'h05, 4'd3));
    chk("sub_zero", 32'(flag_zero), 32'd1);
    send(mk(4'd12, 2'b00, 8'h00, 8'h40, 4'd0));
    chk("jz_ip", 32'(instruction_pointer), 32'h0040);
    send(mk(4'd13, 2'b00, 8'h12, 8'h34, 4'd0));
    chk("jc_ip", 32'(instruction_pointer), 32'h0041);

    // Logic, shifts, moves, compare
    send(mk(4'd3, 2'b00, 8'hF0, 8'h3C, 4'd6));
    send(mk(4'd4, 2'b10, 8'h06, 8'h0F, 4'd7));
    lit("or_reg7", 4'd7, 8'h3F);
    send(mk(4'd5, 2'b00, 8'h3F, 8'h3F, 4'd8));
    send(mk(4'd6, 2'b00, 8'h81, 8'h00, 4'd9));
    lit("shl_reg9", 4'd9, 8'h02);
    chk("shl_carry", 32'(flag_carry), 32'd1);
    send(mk(4'd7, 2'b00, 8'h03, 8'h00, 4'd10));
    send(mk(4'd8, 2'b00, 8'hC5, 8'h00, 4'd11));
    send(mk(4'd8, 2'b10, 8'h08, 8'h00, 4'd12));
    send(mk(4'd14, 2'b00, 8'h03, 8'h05, 4'd6));
    lit("cmp_no_write", 4'd6, 8'h30);
    send(mk(4'd2, 2'b00, 8'h10, 8'h20, 4'd13));
    send(mk(4'd0, 2'b00, 8'h00, 8'h00, 4'd0));
    check_regs("alu_regs");

    // IP wrap from all-ones
    send(mk(4'd11, 2'b00, 8'hFF, 8'hFF, 4'd0));
    send(mk(4'd0, 2'b00, 8'h00, 8'h00, 4'd0));
    chk("ip_wrap", 32'(instruction_pointer), 32'd0);

    // Load with wait states, then store with ack on the first request cycle
    mem_op(mk(4'd9, 2'b00, 8'h12, 8'h34, 4'd5), 3, 8'hAB);
    lit("load_reg5", 4'd5, 8'hAB);
    mem_op(mk(4'd10, 2'b00, 8'h56, 8'h78, 4'd5), 0, 8'h00);
    check_regs("mem_regs");

    // Reset asserted mid MEM_WAIT
    wait_ready();
    instr = mk(4'd9, 2'b00, 8'h22, 8'h33, 4'd1); instr_valid = 1'b1;
    @(posedge clock); #1;
    instr_valid = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    chk("wait_req_up", 32'(mem_req), 32'd1);
    #5 reset_n = 1'b0;
    #1;
    model_reset();
    chk("async_mem_req", 32'(mem_req), 32'd0);
    chk("async_ip", 32'(instruction_pointer), 32'd0);
    chk("async_ready", 32'(instr_ready), 32'd0);
    check_regs("async_regs");
    @(posedge clock); #3 reset_n = 1'b1;
    @(posedge clock); #1;
    chk("ready_after_rst2", 32'(instr_ready), 32'd1);
    idle();

    // Halt, then instructions that must be ignored
    send(mk(4'd1, 2'b00, 8'h03, 8'h04, 4'd7));
    wait_ready();
    instr = mk(4'd15, 2'b00, 8'h00, 8'h00, 4'd0); instr_valid = 1'b1;
    @(posedge clock); #1;
    model_exec(instr, 8'h00);
    instr = mk(4'd1, 2'b00, 8'h11, 8'h22, 4'd7);
    @(posedge clock); #1;
    chk("halted_set", 32'(halted), 32'd1);
    chk("halt_ready", 32'(instr_ready), 32'd0);
    cmp_en = 1'b1;
    repeat (5) @(posedge clock);
    #1;
    cmp_en = 1'b0;
    instr_valid = 1'b0;
    chk("halt_ip_frozen", 32'(instruction_pointer), 32'd1);
    lit("halt_reg7", 4'd7, 8'h07);
    check_regs("halt_regs");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
